pll_region_reconfig: RTL and testbench

- Avalon-MM master for the Altera PLL reconfiguration IP. The IP's reconfig_to_pll/reconfig_from_pll buses connect to the 4-output system PLL (74.25 MHz ref; 85.909/21.477/10.739/10.739-phase MHz outputs).
- On a region change it reprograms the PLL between the NTSC and PAL master clock sets by rewriting M, fractional K and C0..C3.
- Holds the SNES core in reset until the PLL relocks and is stable.

---
 rtl/pll_region_reconfig.sv | 163 ++++++++++++++++
 tb/tb_pll_region_reconfig.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_region_reconfig.sv
// Region-switch controller for the system PLL: rewrites M, K and C0..C3 through the
// reconfiguration IP's Avalon-MM port and holds the core in reset until the PLL is stable.
module pll_region_reconfig #(
    parameter logic [15:0]  M_HILO       = 16'h0404,
    parameter logic [31:0]  K_NTSC       = 32'd425942753,
    parameter logic [31:0]  K_PAL        = 32'd108653128,
    parameter logic [15:0]  C0_HILO      = 16'h0403,
    parameter logic [15:0]  C1_HILO      = 16'h0E0E,
    parameter logic [15:0]  C2_HILO      = 16'h1C1C,
    parameter logic [15:0]  C3_HILO      = 16'h1C1C,
    parameter int unsigned  POLL_TIMEOUT = 65535,
    parameter int unsigned  LOCK_STABLE  = 1024
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        pal,
    input  logic        pll_locked,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_read,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    output logic        busy,
    output logic        mode_pal,
    output logic        core_reset,
    output logic        error
);

    localparam int unsigned PW = $clog2(POLL_TIMEOUT + 1);
    localparam int unsigned LW = $clog2(LOCK_STABLE + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_MODE, S_WR_M, S_WR_K, S_WR_C0, S_WR_C1, S_WR_C2, S_WR_C3,
        S_WR_START, S_POLL, S_WAIT_LOCK
    } state_t;

    state_t          state;
    state_t          wr_next;
    logic            target;
    logic [PW-1:0]   poll_cnt;
    logic [LW-1:0]   lock_cnt;
    logic [1:0]      pal_sync;
    logic [1:0]      lock_sync;
    logic            pal_s;
    logic            lock_s;
    logic [5:0]      wr_addr;
    logic [31:0]     wr_data;
    logic            poll_done;
    logic            unused_rd;

    // Synchronisers are left out of reset so lock status survives a controller reset
    always_ff @(posedge refclk) begin
        pal_sync  <= {pal_sync[0], pal};
        lock_sync <= {lock_sync[0], pll_locked};
    end

    assign pal_s     = pal_sync[1];
    assign lock_s    = lock_sync[1];
    assign poll_done = mgmt_read && !mgmt_waitrequest && mgmt_readdata[0];
    assign unused_rd = ^mgmt_readdata[31:1];

    // Register address/payload for the write owned by each write state
    always_comb begin
        wr_addr = 6'd0;
        wr_data = 32'd0;
        wr_next = S_POLL;
        case (state)
            S_WR_MODE:  begin wr_addr = 6'd0; wr_data = 32'h1;                                   wr_next = S_WR_M;     end
            S_WR_M:     begin wr_addr = 6'd4; wr_data = {16'b0, M_HILO};                         wr_next = S_WR_K;     end
            S_WR_K:     begin wr_addr = 6'd7; wr_data = target ? K_PAL : K_NTSC;                 wr_next = S_WR_C0;    end
            S_WR_C0:    begin wr_addr = 6'd5; wr_data = {9'b0, 5'd0, 1'b1, 1'b0, C0_HILO};       wr_next = S_WR_C1;    end
            S_WR_C1:    begin wr_addr = 6'd5; wr_data = {9'b0, 5'd1, 1'b0, 1'b0, C1_HILO};       wr_next = S_WR_C2;    end
            S_WR_C2:    begin wr_addr = 6'd5; wr_data = {9'b0, 5'd2, 1'b0, 1'b0, C2_HILO};       wr_next = S_WR_C3;    end
            S_WR_C3:    begin wr_addr = 6'd5; wr_data = {9'b0, 5'd3, 1'b0, 1'b0, C3_HILO};       wr_next = S_WR_START; end
            S_WR_START: begin wr_addr = 6'd2; wr_data = 32'h1;                                   wr_next = S_POLL;     end
            default: ;
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state          <= S_WAIT_LOCK;
            mgmt_address   <= 6'd0;
            mgmt_read      <= 1'b0;
            mgmt_write     <= 1'b0;
            mgmt_writedata <= 32'd0;
            busy           <= 1'b0;
            mode_pal       <= 1'b0;
            core_reset     <= 1'b1;
            error          <= 1'b0;
            target         <= 1'b0;
            poll_cnt       <= '0;
            lock_cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!lock_s) begin
                        core_reset <= 1'b1;
                        lock_cnt   <= '0;
                        state      <= S_WAIT_LOCK;
                    end else if (pal_s != mode_pal) begin
                        target     <= pal_s;
                        core_reset <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_WR_MODE;
                    end
                end
                S_WR_MODE, S_WR_M, S_WR_K, S_WR_C0, S_WR_C1, S_WR_C2, S_WR_C3, S_WR_START: begin
                    // Strobe is raised once; address/data stay frozen until the IP accepts
                    if (!mgmt_write) begin
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= wr_addr;
                        mgmt_writedata <= wr_data;
                    end else if (!mgmt_waitrequest) begin
                        mgmt_write <= 1'b0;
                        poll_cnt   <= '0;
                        state      <= wr_next;
                    end
                end
                S_POLL: begin
                    poll_cnt <= poll_cnt + PW'(1);
                    if (poll_done) begin
                        mgmt_read <= 1'b0;
                        mode_pal  <= target;
                        lock_cnt  <= '0;
                        state     <= S_WAIT_LOCK;
                    end else if (poll_cnt + PW'(1) == PW'(POLL_TIMEOUT)) begin
                        mgmt_read <= 1'b0;
                        error     <= 1'b1;
                        lock_cnt  <= '0;
                        state     <= S_WAIT_LOCK;
                    end else if (mgmt_read) begin
                        if (!mgmt_waitrequest) mgmt_read <= 1'b0;
                    end else begin
                        mgmt_read    <= 1'b1;
                        mgmt_address <= 6'd1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (!lock_s) begin
                        lock_cnt <= '0;
                    end else if (lock_cnt + LW'(1) == LW'(LOCK_STABLE)) begin
                        lock_cnt   <= '0;
                        core_reset <= 1'b0;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        lock_cnt <= lock_cnt + LW'(1);
                    end
                end
                default: begin
                    mgmt_read  <= 1'b0;
                    mgmt_write <= 1'b0;
                    core_reset <= 1'b1;
                    lock_cnt   <= '0;
                    state      <= S_WAIT_LOCK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_region_reconfig.sv
// Directed bench for pll_region_reconfig: Avalon slave/monitor plus a linear list of
// region-switch, stall, timeout, lock-loss and reset scenarios.
module tb_pll_region_reconfig;

    localparam int unsigned LS = 16;
    localparam int unsigned PT = 40;
    localparam logic [31:0] KN = 32'd425942753;
    localparam logic [31:0] KP = 32'd108653128;

    logic        refclk = 1'b0;
    logic        rst;
    logic        pal;
    logic        pll_locked;
    logic [5:0]  mgmt_address;
    logic        mgmt_read;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;
    logic        busy;
    logic        mode_pal;
    logic        core_reset;
    logic        error;

    int tests = 0;
    int fails = 0;
    int rd_count = 0;
    int prot_err = 0;
    int rd_base = 0;
    int status_n = 0;
    int wr_base = 0;
    int tgt = 0;
    int n = 0;
    logic [37:0] wr_log[$];

    always #5 refclk = ~refclk;

    pll_region_reconfig #(.POLL_TIMEOUT(PT), .LOCK_STABLE(LS)) dut (
        .refclk(refclk), .rst(rst), .pal(pal), .pll_locked(pll_locked),
        .mgmt_address(mgmt_address), .mgmt_read(mgmt_read), .mgmt_write(mgmt_write),
        .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
        .mgmt_waitrequest(mgmt_waitrequest), .busy(busy), .mode_pal(mode_pal),
        .core_reset(core_reset), .error(error)
    );

    // Status register: bit0 reads back 1 from the status_n-th read after rd_base
    assign mgmt_readdata = (status_n != 0 && (rd_count - rd_base) >= status_n) ? 32'h1 : 32'h0;

    // Bus monitor: logs accepted accesses and counts handshake violations
    logic        p_rd = 1'b0, p_wr = 1'b0, p_wait = 1'b0;
    logic [5:0]  p_addr = 6'd0;
    logic [31:0] p_data = 32'd0;
    always @(negedge refclk) begin
        if (mgmt_read && mgmt_write) prot_err++;
        if ((p_rd || p_wr) && p_wait &&
            {mgmt_read, mgmt_write, mgmt_address, mgmt_writedata} != {p_rd, p_wr, p_addr, p_data})
            prot_err++;
        if ((p_rd || p_wr) && !p_wait && (mgmt_read || mgmt_write)) prot_err++;
        if (mgmt_write && !mgmt_waitrequest) wr_log.push_back({mgmt_address, mgmt_writedata});
        if (mgmt_read && !mgmt_waitrequest) rd_count++;
        p_rd   = mgmt_read;
        p_wr   = mgmt_write;
        p_wait = mgmt_waitrequest;
        p_addr = mgmt_address;
        p_data = mgmt_writedata;
    end

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cond(input int sel);
        case (sel)
            0: return mode_pal;
            1: return !mode_pal;
            2: return !core_reset;
            3: return error;
            4: return mgmt_write && mgmt_address == 6'd7;
            5: return mgmt_write && mgmt_address == 6'd5 && mgmt_writedata == 32'h0008_1C1C;
            6: return wr_log.size() >= tgt;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int max, input string tag, output int cnt);
        cnt = 0;
        while (!cond(sel) && cnt < max) begin
            tick();
            cnt++;
        end
        chk(tag, 64'(cond(sel)), 64'd1);
    endtask

    task automatic chk_seq(input int base, input logic [31:0] k, input string tag);
        logic [5:0]  ea [8];
        logic [31:0] ed [8];
        logic [37:0] obs;
        ea = '{6'd0, 6'd4, 6'd7, 6'd5, 6'd5, 6'd5, 6'd5, 6'd2};
        ed = '{32'h1, 32'h0000_0404, k, 32'h0002_0403, 32'h0004_0E0E,
               32'h0008_1C1C, 32'h000C_1C1C, 32'h1};
        for (int i = 0; i < 8; i++) begin
            obs = (base + i < wr_log.size()) ? wr_log[base + i] : '1;
            chk($sformatf("%s_wr%0d", tag, i), 64'(obs), 64'({ea[i], ed[i]}));
        end
    endtask

    initial begin
        rst = 1'b1; pal = 1'b0; pll_locked = 1'b0; mgmt_waitrequest = 1'b0;

        // Boot: reset values, then release LS cycles after synchronised lock
        repeat (4) tick();
        chk("rst_strobes", 64'({mgmt_read, mgmt_write}), 64'd0);
        chk("rst_addr_data", 64'({mgmt_address, mgmt_writedata}), 64'd0);
        chk("rst_status", 64'({busy, mode_pal, core_reset, error}), 64'b0010);
        rst = 1'b0;
        repeat (5) tick();
        pll_locked = 1'b1;
        repeat (LS + 1) tick();
        chk("boot_hold", 64'({busy, core_reset}), 64'b01);
        tick();
        chk("boot_release", 64'({busy, mode_pal, core_reset}), 64'b000);
        chk("boot_no_access", 64'(wr_log.size() + rd_count), 64'd0);

        // NTSC -> PAL, status set on 3rd read
        rd_base = rd_count; wr_base = wr_log.size(); status_n = 3;
        pal = 1'b1;
        repeat (2) tick();
        chk("switch_pre", 64'(core_reset), 64'd0);
        tick();
        chk("switch_creset", 64'({busy, core_reset}), 64'b11);
        wait_for(0, 200, "pal_applied", n);
        chk("pal_wr_count", 64'(wr_log.size() - wr_base), 64'd8);
        chk_seq(wr_base, KP, "pal");
        chk("pal_reads", 64'(rd_count - rd_base), 64'd3);
        wait_for(2, LS + 10, "pal_release", n);
        chk("pal_final", 64'({busy, mode_pal}), 64'b01);

        // PAL -> NTSC with waitrequest stalling the K write for 5 cycles
        rd_base = rd_count; wr_base = wr_log.size(); status_n = 1;
        pal = 1'b0;
        wait_for(4, 100, "k_write_seen", n);
        chk("k_data", 64'(mgmt_writedata), 64'(KN));
        mgmt_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("k_hold%0d", i), 64'({mgmt_write, mgmt_read, mgmt_address, mgmt_writedata}),
                64'({1'b1, 1'b0, 6'd7, KN}));
        end
        mgmt_waitrequest = 1'b0;
        tick();
        chk("k_drop", 64'(mgmt_write), 64'd0);
        tick();
        chk("after_k", 64'({mgmt_write, mgmt_address}), 64'({1'b1, 6'd5}));
        wait_for(1, 200, "ntsc_applied", n);
        wait_for(2, LS + 10, "ntsc_release", n);
        chk_seq(wr_base, KN, "ntsc");

        // pal 0->1->0 mid-sequence: PAL finishes, then an NTSC sequence follows
        rd_base = rd_count; wr_base = wr_log.size(); status_n = 1;
        pal = 1'b1;
        tgt = wr_base + 3;
        wait_for(6, 100, "tog_k_written", n);
        pal = 1'b0;
        wait_for(0, 200, "tog_pal_applied", n);
        chk("tog_busy", 64'(busy), 64'd1);
        wait_for(2, LS + 10, "tog_release1", n);
        wait_for(1, 300, "tog_ntsc_applied", n);
        wait_for(2, LS + 10, "tog_release2", n);
        chk("tog_wr_count", 64'(wr_log.size() - wr_base), 64'd16);
        chk_seq(wr_base, KP, "tog1");
        chk_seq(wr_base + 8, KN, "tog2");

        // Lock loss for 3 cycles while idle
        wr_base = wr_log.size();
        pll_locked = 1'b0;
        repeat (2) tick();
        chk("lol_pre", 64'(core_reset), 64'd0);
        tick();
        chk("lol_creset", 64'(core_reset), 64'd1);
        pll_locked = 1'b1;
        repeat (LS + 1) tick();
        chk("lol_hold", 64'(core_reset), 64'd1);
        tick();
        chk("lol_release", 64'({core_reset, mode_pal}), 64'b00);
        chk("lol_no_access", 64'(wr_log.size() - wr_base), 64'd0);

        // rst during the C2 write with pal high: strobes clear, switch reruns after lock
        rd_base = rd_count; status_n = 1;
        pal = 1'b1;
        wait_for(5, 100, "c2_write_seen", n);
        rst = 1'b1;
        tick();
        chk("rst_mid_strobes", 64'({mgmt_read, mgmt_write}), 64'd0);
        chk("rst_mid_status", 64'({busy, mode_pal, core_reset, error}), 64'b0010);
        rst = 1'b0;
        wr_base = wr_log.size();
        repeat (LS - 1) tick();
        chk("rst_mid_hold", 64'(core_reset), 64'd1);
        tick();
        chk("rst_mid_release", 64'(core_reset), 64'd0);
        wait_for(0, 200, "rerun_pal_applied", n);
        wait_for(2, LS + 10, "rerun_release", n);
        chk_seq(wr_base, KP, "rerun");

        // Status never sets: sticky error, mode_pal unchanged, then a clean retry
        rd_base = rd_count; wr_base = wr_log.size(); status_n = 0;
        pal = 1'b0;
        tgt = wr_base + 8;
        wait_for(6, 100, "to_start_written", n);
        wait_for(3, PT + 20, "to_error", n);
        chk("to_window", 64'(n >= PT - 1 && n <= PT + 1), 64'd1);
        chk("to_state", 64'({mgmt_read, mode_pal, core_reset, error}), 64'b0111);
        status_n = 1;
        wait_for(2, LS + 10, "to_release", n);
        wait_for(1, 200, "to_retry_applied", n);
        wait_for(2, LS + 10, "to_retry_release", n);
        chk("to_sticky", 64'(error), 64'd1);
        chk_seq(wr_base + 8, KN, "retry");

        chk("protocol", 64'(prot_err), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
